// File: rtl/xv.sv
// Shared Xosera bus package: bus polarity constants, host-initiator FSM states
// and small helpers used by the host bus initiator.
package xv;

  localparam logic CS_ENABLED  = 1'b0;
  localparam logic CS_DISABLED = 1'b1;
  localparam logic RnW_READ    = 1'b1;
  localparam logic RnW_WRITE   = 1'b0;
  localparam logic DTACK_N_ACK = 1'b0;
  localparam logic DTACK_N_NAK = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } host_bus_state_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bus_phase_timer.sv
// Loadable down-counter with zero flag; saturates at zero so a phase can
// outlast its minimum length without wrapping.
module bus_phase_timer #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/host_bus_initiator.sv
// Host-side Xosera 8-bit register bus driver: one 16-bit request becomes two
// byte cycles. Define HOST_BUS_DTACK_WAIT_EN to stretch strobes until DTACK.
//
// state  | meaning
// IDLE   | ready for a request
// SETUP  | address/data driven, CS disabled
// STROBE | CS enabled, read byte captured on exit
// HOLD   | CS disabled, outputs held
// DONE   | one-cycle response pulse
module host_bus_initiator
  import xv::*;
#(
  parameter int SETUP_CYCLES   = 2,
  parameter int STROBE_CYCLES  = 6,
  parameter int HOLD_CYCLES    = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wr_i,
  input  logic [3:0]  req_reg_num_i,
  input  logic [15:0] req_data_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_data_o,
  output logic        rsp_timeout_o,
  output logic        bus_cs_n_o,
  output logic        bus_rd_nwr_o,
  output logic [3:0]  bus_reg_num_o,
  output logic        bus_bytesel_o,
  output logic [7:0]  bus_data_o,
  output logic        bus_data_oe_o,
  input  logic [7:0]  bus_data_i,
  input  logic        bus_dtack_n_i
);

  localparam int CNT_MAX = max_of(max_of(SETUP_CYCLES, STROBE_CYCLES),
                                  max_of(HOLD_CYCLES, TIMEOUT_CYCLES));
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  host_bus_state_t state, state_next;

  logic             wr_q;
  logic [15:0]      data_q;
  logic             byte_idx;
  logic             tmo_flag;

  logic             accept, next_byte, capture, timed_out, tmo_load;
  logic             phase_load, phase_zero;
  logic [CNT_W-1:0] phase_value;
  logic             strobe_done, strobe_tmo;

  bus_phase_timer #(.WIDTH(CNT_W)) u_phase_timer (
    .clk        (clk),
    .reset      (reset_i),
    .load       (phase_load),
    .en         (1'b1),
    .load_value (phase_value),
    .zero       (phase_zero)
  );

`ifdef HOST_BUS_DTACK_WAIT_EN
  logic [1:0] dtack_sync;
  logic       nak_seen;
  logic       tmo_zero;
  logic       ack_ok;

  bus_phase_timer #(.WIDTH(CNT_W)) u_timeout_timer (
    .clk        (clk),
    .reset      (reset_i),
    .load       (tmo_load),
    .en         (state == STROBE),
    .load_value (CNT_W'(TIMEOUT_CYCLES - 1)),
    .zero       (tmo_zero)
  );

  // An ACK left over from the previous byte must not end the new strobe.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      dtack_sync <= {DTACK_N_NAK, DTACK_N_NAK};
      nak_seen   <= 1'b0;
    end else begin
      dtack_sync <= {dtack_sync[0], bus_dtack_n_i};
      if (accept || next_byte) begin
        nak_seen <= 1'b0;
      end else if (((state == SETUP) || (state == STROBE)) &&
                   (dtack_sync[1] == DTACK_N_NAK)) begin
        nak_seen <= 1'b1;
      end
    end
  end

  assign ack_ok        = (dtack_sync[1] == DTACK_N_ACK) && nak_seen;
  assign strobe_done   = phase_zero && ack_ok;
  assign strobe_tmo    = tmo_zero && !strobe_done;
  assign rsp_timeout_o = tmo_flag;
`else
  logic unused_dtack;
  assign unused_dtack  = ^{bus_dtack_n_i, tmo_load, tmo_flag};
  assign strobe_done   = phase_zero;
  assign strobe_tmo    = 1'b0;
  assign rsp_timeout_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    next_byte   = 1'b0;
    capture     = 1'b0;
    timed_out   = 1'b0;
    tmo_load    = 1'b0;
    phase_load  = 1'b0;
    phase_value = '0;
    case (state)
      IDLE: begin
        if (req_valid_i) begin
          accept      = 1'b1;
          state_next  = SETUP;
          phase_load  = 1'b1;
          phase_value = CNT_W'(SETUP_CYCLES - 1);
        end
      end
      SETUP: begin
        if (phase_zero) begin
          state_next  = STROBE;
          phase_load  = 1'b1;
          phase_value = CNT_W'(STROBE_CYCLES - 1);
          tmo_load    = 1'b1;
        end
      end
      STROBE: begin
        if (strobe_done || strobe_tmo) begin
          state_next  = HOLD;
          phase_load  = 1'b1;
          phase_value = CNT_W'(HOLD_CYCLES - 1);
          capture     = !wr_q;
          timed_out   = strobe_tmo;
        end
      end
      HOLD: begin
        if (phase_zero) begin
          if (!byte_idx) begin
            state_next  = SETUP;
            next_byte   = 1'b1;
            phase_load  = 1'b1;
            phase_value = CNT_W'(SETUP_CYCLES - 1);
          end else begin
            state_next = DONE;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      wr_q          <= 1'b0;
      data_q        <= '0;
      byte_idx      <= 1'b0;
      tmo_flag      <= 1'b0;
      rsp_data_o    <= '0;
      bus_cs_n_o    <= CS_DISABLED;
      bus_rd_nwr_o  <= RnW_READ;
      bus_reg_num_o <= '0;
      bus_bytesel_o <= 1'b0;
      bus_data_o    <= '0;
      bus_data_oe_o <= 1'b0;
    end else begin
      bus_cs_n_o <= (state_next == STROBE) ? CS_ENABLED : CS_DISABLED;
      if (accept) begin
        wr_q          <= req_wr_i;
        data_q        <= req_data_i;
        byte_idx      <= 1'b0;
        tmo_flag      <= 1'b0;
        bus_rd_nwr_o  <= req_wr_i ? RnW_WRITE : RnW_READ;
        bus_reg_num_o <= req_reg_num_i;
        bus_bytesel_o <= 1'b0;
        bus_data_o    <= req_data_i[15:8];
        bus_data_oe_o <= req_wr_i;
      end
      if (next_byte) begin
        byte_idx      <= 1'b1;
        bus_bytesel_o <= 1'b1;
        bus_data_o    <= data_q[7:0];
      end
      if (capture) begin
        if (!byte_idx) begin
          rsp_data_o[15:8] <= bus_data_i;
        end else begin
          rsp_data_o[7:0] <= bus_data_i;
        end
      end
      if (timed_out) begin
        tmo_flag <= 1'b1;
      end
      if (state_next == DONE) begin
        bus_data_oe_o <= 1'b0;
      end
    end
  end

  assign req_ready_o = (state == IDLE);
  assign rsp_valid_o = (state == DONE);

endmodule

// File: tb/tb_host_bus_initiator.sv
// Self-checking bench for host_bus_initiator: table of fixed-timing transactions
// plus reset-abort, back-to-back and (HOST_BUS_DTACK_WAIT_EN) DTACK sequences.
module tb_host_bus_initiator;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_wr_i = 1'b0;
  logic [3:0]  req_reg_num_i = '0;
  logic [15:0] req_data_i = '0;
  logic        rsp_valid_o;
  logic [15:0] rsp_data_o;
  logic        rsp_timeout_o;
  logic        bus_cs_n_o;
  logic        bus_rd_nwr_o;
  logic [3:0]  bus_reg_num_o;
  logic        bus_bytesel_o;
  logic [7:0]  bus_data_o;
  logic        bus_data_oe_o;
  logic [7:0]  bus_data_i;
  logic        bus_dtack_n_i;

  host_bus_initiator dut (
    .clk           (clk),
    .reset_i       (reset_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_wr_i      (req_wr_i),
    .req_reg_num_i (req_reg_num_i),
    .req_data_i    (req_data_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_data_o    (rsp_data_o),
    .rsp_timeout_o (rsp_timeout_o),
    .bus_cs_n_o    (bus_cs_n_o),
    .bus_rd_nwr_o  (bus_rd_nwr_o),
    .bus_reg_num_o (bus_reg_num_o),
    .bus_bytesel_o (bus_bytesel_o),
    .bus_data_o    (bus_data_o),
    .bus_data_oe_o (bus_data_oe_o),
    .bus_data_i    (bus_data_i),
    .bus_dtack_n_i (bus_dtack_n_i)
  );

  always #5 clk = ~clk;

  // Responder: byte data by bytesel; DTACK after ack_after CS-low clocks (0 = never).
  logic [7:0] even_val = 8'h00, odd_val = 8'h00;
  int ack_after = 1;
  int cs_cnt = 0;
  always @(posedge clk) cs_cnt <= (bus_cs_n_o == 1'b0) ? cs_cnt + 1 : 0;
  assign bus_data_i = bus_bytesel_o ? odd_val : even_val;
  assign bus_dtack_n_i = (ack_after > 0 && bus_cs_n_o == 1'b0 && cs_cnt >= ack_after - 1) ? 1'b0 : 1'b1;

  typedef struct {
    int         w;
    int         gap;
    logic       bs;
    logic [7:0] d;
    logic       rnw;
    logic       oe;
    logic [3:0] rn;
    logic       stable;
  } pulse_t;

  pulse_t pq[$];
  pulse_t cur;
  int     acc_q[$];
  int     rsp_q[$];
  int     cyc = 0, cur_w = 0, gap = 0;
  logic   oe_seen = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (reset_i) begin
      cur_w = 0;
      gap   = 0;
    end else if (bus_cs_n_o == 1'b0) begin
      if (cur_w == 0) begin
        cur.gap = gap; cur.bs = bus_bytesel_o; cur.d = bus_data_o;
        cur.rnw = bus_rd_nwr_o; cur.oe = bus_data_oe_o; cur.rn = bus_reg_num_o;
        cur.stable = 1'b1;
      end else if ({cur.bs, cur.d, cur.rnw, cur.oe, cur.rn} !==
                   {bus_bytesel_o, bus_data_o, bus_rd_nwr_o, bus_data_oe_o, bus_reg_num_o}) begin
        cur.stable = 1'b0;
      end
      cur_w++;
      gap = 0;
    end else begin
      if (cur_w > 0) begin
        cur.w = cur_w;
        pq.push_back(cur);
        cur_w = 0;
      end
      gap++;
    end
    if (!reset_i && req_valid_i && req_ready_o) acc_q.push_back(cyc);
    if (rsp_valid_o) rsp_q.push_back(cyc);
    if (bus_data_oe_o) oe_seen = 1'b1;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_req(input logic wr, input logic [3:0] rn, input logic [15:0] d,
                         input int max_cyc, output int lat, output logic [15:0] rdata,
                         output logic tmo, output logic ok);
    @(negedge clk);
    pq.delete();
    oe_seen = 1'b0;
    req_valid_i = 1'b1; req_wr_i = wr; req_reg_num_i = rn; req_data_i = d;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    lat = 1;
    ok  = 1'b0;
    while (lat <= max_cyc) begin
      @(negedge clk);
      if (rsp_valid_o) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    rdata = rsp_data_o;
    tmo   = rsp_timeout_o;
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  rn;
    logic [15:0] d;
    logic [7:0]  ev;
    logic [7:0]  od;
    logic [7:0]  exp_d0;
    logic [7:0]  exp_d1;
    logic [15:0] exp_rsp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lat;
    logic [15:0] rdata;
    logic tmo, ok;
    string tag;

    vecs[0] = '{1'b1, 4'h4, 16'hA55A, 8'h00, 8'h00, 8'hA5, 8'h5A, 16'h0000};
    vecs[1] = '{1'b0, 4'hB, 16'h0000, 8'h12, 8'h34, 8'h00, 8'h00, 16'h1234};
    vecs[2] = '{1'b1, 4'h0, 16'h00FF, 8'h00, 8'h00, 8'h00, 8'hFF, 16'h0000};
    vecs[3] = '{1'b0, 4'hF, 16'h5555, 8'hBE, 8'hEF, 8'h00, 8'h00, 16'hBEEF};
    vecs[4] = '{1'b1, 4'h7, 16'h8001, 8'h00, 8'h00, 8'h80, 8'h01, 16'h0000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", bus_cs_n_o, 1);
    chk("rst_rd_nwr", bus_rd_nwr_o, 1);
    chk("rst_bus_misc", {bus_reg_num_o, bus_bytesel_o, bus_data_o, bus_data_oe_o}, 0);
    chk("rst_ready", req_ready_o, 1);
    chk("rst_rsp", {rsp_valid_o, rsp_data_o, rsp_timeout_o}, 0);
    reset_i = 1'b0;

    // Table: fixed-length strobes (in DTACK builds the ack is immediate, so 6 still wins).
    ack_after = 1;
    for (int i = 0; i < 5; i++) begin
      even_val = vecs[i].ev;
      odd_val  = vecs[i].od;
      tag = $sformatf("vec%0d", i);
      run_req(vecs[i].wr, vecs[i].rn, vecs[i].d, 60, lat, rdata, tmo, ok);
      chk({tag, "_rsp_seen"}, ok, 1);
      chk({tag, "_latency"}, lat, 23);
      chk({tag, "_timeout"}, tmo, 0);
      chk({tag, "_npulses"}, pq.size(), 2);
      if (pq.size() == 2) begin
        chk({tag, "_w0"}, pq[0].w, 6);
        chk({tag, "_w1"}, pq[1].w, 6);
        chk({tag, "_gap"}, pq[1].gap, 5);
        chk({tag, "_bs"}, {pq[0].bs, pq[1].bs}, 2'b01);
        chk({tag, "_rnw"}, {pq[0].rnw, pq[1].rnw}, {2{~vecs[i].wr}});
        chk({tag, "_reg"}, {pq[0].rn, pq[1].rn}, {2{vecs[i].rn}});
        chk({tag, "_stable"}, {pq[0].stable, pq[1].stable}, 2'b11);
        chk({tag, "_oe"}, {pq[0].oe, pq[1].oe}, {2{vecs[i].wr}});
        if (vecs[i].wr)
          chk({tag, "_wdata"}, {pq[0].d, pq[1].d}, {vecs[i].exp_d0, vecs[i].exp_d1});
      end
      if (!vecs[i].wr) begin
        chk({tag, "_rdata"}, rdata, vecs[i].exp_rsp);
        chk({tag, "_oe_never"}, oe_seen, 0);
      end
    end

    // Reset during byte-0 strobe aborts the request silently.
    @(negedge clk);
    req_valid_i = 1'b1; req_wr_i = 1'b1; req_reg_num_i = 4'h5; req_data_i = 16'hCAFE;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    begin
      int n = 0;
      while (bus_cs_n_o !== 1'b0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("abort_cs_low_seen", bus_cs_n_o, 0);
    end
    @(negedge clk);
    reset_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_cs_n", bus_cs_n_o, 1);
    chk("abort_ready", req_ready_o, 1);
    reset_i = 1'b0;
    rsp_q.delete();
    repeat (30) @(negedge clk);
    chk("abort_no_rsp", rsp_q.size(), 0);
    run_req(1'b1, 4'h2, 16'h0001, 60, lat, rdata, tmo, ok);
    chk("post_abort_rsp_seen", ok, 1);
    chk("post_abort_latency", lat, 23);
    chk("post_abort_npulses", pq.size(), 2);
    if (pq.size() == 2) chk("post_abort_wdata", {pq[0].d, pq[1].d}, 16'h0001);

    // Back-to-back with valid held high.
    @(negedge clk);
    pq.delete(); acc_q.delete(); rsp_q.delete();
    req_valid_i = 1'b1; req_wr_i = 1'b1; req_reg_num_i = 4'h3; req_data_i = 16'h1111;
    begin
      int n = 0;
      while (acc_q.size() < 1 && n < 10) begin @(negedge clk); n++; end
      @(negedge clk);
      req_data_i = 16'h2222;
      n = 0;
      while (acc_q.size() < 2 && n < 100) begin @(negedge clk); n++; end
      @(posedge clk);
      #1 req_valid_i = 1'b0;
      n = 0;
      while (rsp_q.size() < 2 && n < 100) begin @(negedge clk); n++; end
      @(negedge clk);
    end
    chk("b2b_accepts", acc_q.size(), 2);
    chk("b2b_rsps", rsp_q.size(), 2);
    if (acc_q.size() == 2 && rsp_q.size() == 2) begin
      chk("b2b_first_latency", rsp_q[0] - acc_q[0], 23);
      chk("b2b_second_after_rsp", acc_q[1] - rsp_q[0], 1);
    end
    chk("b2b_npulses", pq.size(), 4);
    if (pq.size() == 4) begin
      chk("b2b_data", {pq[0].d, pq[1].d, pq[2].d, pq[3].d}, 32'h11112222);
      chk("b2b_gap_intra", pq[1].gap, 5);
      chk("b2b_gap_inter", pq[2].gap, 7);
      chk("b2b_gap_intra2", pq[3].gap, 5);
    end

`ifdef HOST_BUS_DTACK_WAIT_EN
    // Responder acks after 10 CS clocks: width 10 plus 2 synchronizer clocks.
    ack_after = 10;
    even_val = 8'hBE; odd_val = 8'hEF;
    run_req(1'b0, 4'h9, 16'h0000, 100, lat, rdata, tmo, ok);
    chk("dtack_rsp_seen", ok, 1);
    chk("dtack_latency", lat, 35);
    chk("dtack_rdata", rdata, 16'hBEEF);
    chk("dtack_timeout", tmo, 0);
    chk("dtack_npulses", pq.size(), 2);
    if (pq.size() == 2) chk("dtack_widths", {pq[0].w[15:0], pq[1].w[15:0]}, {16'd12, 16'd12});

    // Responder never acks: both strobes time out at 64 clocks.
    ack_after = 0;
    even_val = 8'h3C; odd_val = 8'hC3;
    run_req(1'b0, 4'h1, 16'h0000, 200, lat, rdata, tmo, ok);
    chk("tmo_rsp_seen", ok, 1);
    chk("tmo_latency", lat, 139);
    chk("tmo_flag", tmo, 1);
    chk("tmo_rdata", rdata, 16'h3CC3);
    chk("tmo_npulses", pq.size(), 2);
    if (pq.size() == 2) chk("tmo_widths", {pq[0].w[15:0], pq[1].w[15:0]}, {16'd64, 16'd64});

    // Timeout flag clears on the next request.
    ack_after = 1;
    run_req(1'b1, 4'h6, 16'h4242, 60, lat, rdata, tmo, ok);
    chk("tmo_clear", tmo, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
